fifo_rd_burst_streamer: RTL and testbench
=========================================

Name: fifo_rd_burst_streamer

Overview:
- Sits directly downstream of the width-converting FIFO read port. Drains a commanded number of beats from it and presents them as a valid/ready stream with a last flag, for example to the DDR write or PE-array input path.
- Hides the FIFO's 1-cycle read-data latency behind a 2-entry output buffer, so steady-state throughput is 1 beat/cycle under backpressure.

Parameters:
- DATA_WIDTH, 64, beat width; equals the FIFO read-side width.
- BURST_LEN_W, 8, width of the burst length command.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- burst_start  input  1  command strobe; accepted only when burst_ready=1.
- burst_len  input  BURST_LEN_W  beats in the burst; sampled with burst_start.
- burst_ready  output  1  high only in IDLE.
- burst_done  output  1  one-cycle pulse after the last beat handshake.
- fifo_read_req  output  1  FIFO pop request.
- fifo_read_ready  input  1  FIFO non-empty.
- fifo_read_data  input  DATA_WIDTH  valid the cycle after (fifo_read_req && fifo_read_ready).
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready.
- m_data  output  DATA_WIDTH  stream data.
- m_last  output  1  high on the final beat of the burst.

Behaviour:
- Reset (async) values: state=IDLE, burst_ready=1, burst_done=0, fifo_read_req=0, m_valid=0, m_last=0, m_data=0, all counters=0, buffer empty.
- FSM states: IDLE, STREAM, DONE.
  - IDLE -> STREAM on burst_start with burst_len!=0. Loads issue_cnt and beat_cnt with burst_len.
  - burst_start with burst_len=0 is ignored: stay in IDLE, no pulse.
  - STREAM -> DONE on the handshake (m_valid && m_ready) where beat_cnt==1.
  - DONE -> IDLE unconditionally. burst_done=1 in DONE only.
- burst_start outside IDLE is ignored. It is not queued.
- Pop condition:
  - fifo_read_req = (state==STREAM) && issue_cnt!=0 && (occ + inflight < 2 || pop_out).
  - occ = buffer entries; inflight = read issued last cycle; pop_out = m_valid && m_ready.
  - A pop occurs when fifo_read_req && fifo_read_ready; it decrements issue_cnt.
- Capture: inflight data is written into the buffer at the next edge.
  - The buffer is FIFO-ordered, and m_data is its head.
  - The buffer never overflows and never drops a beat.
- Latency: burst_start accepted at edge E0 with the FIFO non-empty gives fifo_read_req high in the cycle after E0, data captured at E2, and m_valid high after E2.
  - With m_ready held high and the FIFO non-empty, beats are back-to-back at 1/cycle.
- m_last = m_valid && (beat_cnt==1). beat_cnt decrements on every handshake.
- m_valid/m_data are held stable while m_ready=0.
- FIFO empty mid-burst: fifo_read_req stays low and the buffer drains. m_valid drops when occ=0 with no inflight, and resumes without loss or duplication.
- m_ready low: at most 2 beats are buffered (occ+inflight<=2), then fifo_read_req deasserts.
- Simultaneous capture and pop_out in the same cycle: occ is unchanged.
- Reset mid-burst: everything clears immediately and buffered/inflight beats are discarded. The FIFO shares the reset, so no pointer skew.
- burst_len maximum 2^BURST_LEN_W-1; counters are BURST_LEN_W bits wide with no wrap.

Optional Feature:
- Macro FIFO_RD_STREAMER_PERF_EN.
- Defined: adds output ports stall_cycles[31:0] and starve_cycles[31:0].
  - stall_cycles counts STREAM cycles with m_valid && !m_ready.
  - starve_cycles counts STREAM cycles with occ==0, no inflight, issue_cnt!=0 and !fifo_read_ready.
  - Both saturate at 2^32-1, clear on reset only, and accumulate across bursts.
- Undefined: ports and counters are absent, and the core behaviour is identical.

Decomposition:
- Shared package/header holds:
  - FSM state encodings STATE_IDLE=2'd0, STATE_STREAM=2'd1, STATE_DONE=2'd2.
  - Buffer depth constant OUT_BUF_DEPTH=2.
- One sub-module, stream_skid_buf2: 2-entry FIFO-ordered buffer with push/pop/occ outputs, instantiated once.

Test Plan:
- burst_len=4, FIFO holding 0xA0..0xA3, m_ready=1 -> fifo_read_req 4 consecutive cycles; m_data A0,A1,A2,A3 on consecutive cycles; m_last only on A3; burst_done one cycle after the A3 handshake; burst_ready returns 1 the cycle after.
- burst_len=6, m_ready toggling 1,0,0,1 repeating -> exactly 6 handshakes in order, data never changes while m_ready=0, occ+inflight never >2.
- burst_len=5, FIFO supplies 2 entries, empty 7 cycles, then 3 more -> m_valid drops after beat 2, resumes, 5 beats in order, m_last on beat 5.
- burst_len=0 pulse, then burst_start during an active burst_len=3 -> both ignored: no fifo_read_req from the first, only 3 beats total, a single burst_done.
- Reset asserted asynchronously mid-burst (beat 2 of 8) -> all outputs take reset values before the next edge; a following burst_len=2 streams cleanly from refilled FIFO data.
- With FIFO_RD_STREAMER_PERF_EN: burst_len=4 with m_ready held 0 for 10 cycles after m_valid rises -> stall_cycles=10. FIFO empty for 5 cycles mid-burst -> starve_cycles=5.

Source files
------------

// File: rtl/fifo_rd_burst_streamer_pkg.sv
// fifo_rd_burst_streamer_pkg: FSM encodings and output buffer sizing shared by the burst streamer
package fifo_rd_burst_streamer_pkg;
  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_STREAM = 2'd1,
    STATE_DONE   = 2'd2
  } state_t;
  localparam int OUT_BUF_DEPTH = 2;
  localparam int OCC_W = $clog2(OUT_BUF_DEPTH + 1);
endpackage

// File: rtl/fifo_rd_burst_streamer_if.sv
// fifo_rd_burst_streamer_if: burst command, FIFO read port and output stream; master is the streamer side
interface fifo_rd_burst_streamer_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_LEN_W = 8
);
  logic                   burst_start;
  logic [BURST_LEN_W-1:0] burst_len;
  logic                   burst_ready;
  logic                   burst_done;
  logic                   fifo_read_req;
  logic                   fifo_read_ready;
  logic [DATA_WIDTH-1:0]  fifo_read_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_last;
  modport master (
    input  burst_start, burst_len, fifo_read_ready, fifo_read_data, m_ready,
    output burst_ready, burst_done, fifo_read_req, m_valid, m_data, m_last
  );
  modport slave (
    output burst_start, burst_len, fifo_read_ready, fifo_read_data, m_ready,
    input  burst_ready, burst_done, fifo_read_req, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_rd_burst_streamer_skid_buf2.sv
// stream_skid_buf2: 2-entry FIFO-ordered buffer; head_o is the oldest entry whenever occ_o != 0
module stream_skid_buf2
  import fifo_rd_burst_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [OCC_W-1:0]      occ_o
);
  logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [OCC_W-1:0]      occ_q, occ_d, slot;
  // a push lands in the slot left after this cycle's pop has shifted the head out
  always_comb begin
    slot  = occ_q - OCC_W'(pop_i);
    occ_d = slot + OCC_W'(push_i);
    e0_d  = (push_i && slot == '0) ? push_data_i : pop_i ? e1_q : e0_q;
    e1_d  = (push_i && slot != '0) ? push_data_i : e1_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  assign head_o = e0_q;
  assign occ_o  = occ_q;
endmodule

// File: rtl/fifo_rd_burst_streamer.sv
// fifo_rd_burst_streamer: drains burst_len beats from the FIFO read port into a valid/ready stream with last.
// Define FIFO_RD_STREAMER_PERF_EN to add the stall_cycles/starve_cycles counters.
module fifo_rd_burst_streamer
  import fifo_rd_burst_streamer_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_LEN_W = 8
) (
  input  logic clk,
  input  logic reset,
  fifo_rd_burst_streamer_if.master bus
`ifdef FIFO_RD_STREAMER_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] starve_cycles
`endif
);
  localparam logic [BURST_LEN_W-1:0] ONE = BURST_LEN_W'(1);
  state_t                 state_q;
  logic [BURST_LEN_W-1:0] issue_cnt_q, beat_cnt_q;
  logic                   inflight_q, burst_ready_q, burst_done_q;
  logic                   pop_out, rd_fire, last_hs;
  logic [OCC_W-1:0]       occ;
  assign pop_out = bus.m_valid && bus.m_ready;
  assign rd_fire = bus.fifo_read_req && bus.fifo_read_ready;
  assign last_hs = pop_out && beat_cnt_q == ONE;
  // a read may issue when a slot will be free once the in-flight beat lands, or the head leaves now
  assign bus.fifo_read_req = state_q == STATE_STREAM && issue_cnt_q != '0 &&
                             (int'(occ) + int'(inflight_q) < OUT_BUF_DEPTH || pop_out);
  assign bus.m_valid     = occ != '0;
  assign bus.m_last      = bus.m_valid && beat_cnt_q == ONE;
  assign bus.burst_ready = burst_ready_q;
  assign bus.burst_done  = burst_done_q;
  stream_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk(clk),
    .rst(reset),
    .push_i(inflight_q),
    .push_data_i(bus.fifo_read_data),
    .pop_i(pop_out),
    .head_o(bus.m_data),
    .occ_o(occ)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q       <= STATE_IDLE;
      issue_cnt_q   <= '0;
      beat_cnt_q    <= '0;
      inflight_q    <= 1'b0;
      burst_ready_q <= 1'b1;
      burst_done_q  <= 1'b0;
    end else begin
      inflight_q <= rd_fire;
      case (state_q)
        STATE_IDLE:
          if (bus.burst_start && bus.burst_len != '0) begin
            state_q       <= STATE_STREAM;
            burst_ready_q <= 1'b0;
            issue_cnt_q   <= bus.burst_len;
            beat_cnt_q    <= bus.burst_len;
          end
        STATE_STREAM: begin
          if (rd_fire) issue_cnt_q <= issue_cnt_q - ONE;
          if (pop_out) beat_cnt_q <= beat_cnt_q - ONE;
          if (last_hs) begin
            state_q      <= STATE_DONE;
            burst_done_q <= 1'b1;
          end
        end
        STATE_DONE: begin
          state_q       <= STATE_IDLE;
          burst_done_q  <= 1'b0;
          burst_ready_q <= 1'b1;
        end
        default: state_q <= STATE_IDLE;
      endcase
    end
`ifdef FIFO_RD_STREAMER_PERF_EN
  logic [31:0] stall_q, starve_q;
  logic        stall_hit, starve_hit;
  assign stall_hit  = state_q == STATE_STREAM && bus.m_valid && !bus.m_ready;
  assign starve_hit = state_q == STATE_STREAM && occ == '0 && !inflight_q &&
                      issue_cnt_q != '0 && !bus.fifo_read_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      if (stall_hit && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (starve_hit && starve_q != '1) starve_q <= starve_q + 32'd1;
    end
  assign stall_cycles  = stall_q;
  assign starve_cycles = starve_q;
`endif
endmodule

// File: tb/tb_fifo_rd_burst_streamer.sv
// tb_fifo_rd_burst_streamer: directed and randomized bursts checked against a queue-based FIFO/stream model
`timescale 1ns/1ps
module tb_fifo_rd_burst_streamer;
  localparam int DW = 64;
  localparam int LW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fifo_rd_burst_streamer_if #(.DATA_WIDTH(DW), .BURST_LEN_W(LW)) bus ();
`ifdef FIFO_RD_STREAMER_PERF_EN
  logic [31:0] stall_cycles, starve_cycles;
  longint stall_m = 0, starve_m = 0;
  fifo_rd_burst_streamer #(.DATA_WIDTH(DW), .BURST_LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .stall_cycles(stall_cycles), .starve_cycles(starve_cycles));
`else
  fifo_rd_burst_streamer #(.DATA_WIDTH(DW), .BURST_LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif
  int checks = 0, passes = 0;
  int phase = 0, len = 0, beats = 0, pops = 0, outstanding = 0, cyc = 0;
  int rdy_mode = 0, acc_cyc = 0, first_hs = 0, last_hs = 0;
  bit fifo_rand = 1'b0;
  logic [DW-1:0] fifo_q[$], exp_q[$];
  logic [DW-1:0] prev_data = '0;
  logic prev_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic refresh();
    bus.fifo_read_ready = (!fifo_rand || $urandom_range(0, 3) != 0) && fifo_q.size() != 0;
  endtask

  task automatic push(input int n, input logic [DW-1:0] base, input bit rnd);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? {$urandom, $urandom} : base + DW'(i);
      fifo_q.push_back(d);
      exp_q.push_back(d);
    end
    refresh();
  endtask

  task automatic cycle();
    logic hs, pop, acc;
    logic [DW-1:0] d;
    @(negedge clk);
    hs  = bus.m_valid && bus.m_ready;
    pop = bus.fifo_read_req && bus.fifo_read_ready;
    acc = phase == 0 && bus.burst_start && bus.burst_len != '0;
    check("burst_ready", 64'(bus.burst_ready), 64'(phase == 0));
    check("burst_done", 64'(bus.burst_done), 64'(phase == 2));
    check("occ_inflight_le2", 64'(outstanding > 2), 64'(0));
    check("m_last", 64'(bus.m_last), 64'(bus.m_valid && phase == 1 && beats + 1 == len));
    if (phase != 1) check("req_outside_burst", 64'(bus.fifo_read_req), 64'(0));
    if (phase == 0) check("valid_idle", 64'(bus.m_valid), 64'(0));
    if (prev_stall) begin
      check("hold_valid", 64'(bus.m_valid), 64'(1));
      check("hold_data", 64'(bus.m_data), 64'(prev_data));
    end
    if (hs) begin
      if (exp_q.size() == 0) check("beat_expected", 64'(exp_q.size()), 64'(1));
      else begin
        d = exp_q.pop_front();
        check("m_data", 64'(bus.m_data), 64'(d));
      end
    end
`ifdef FIFO_RD_STREAMER_PERF_EN
    if (phase == 1 && bus.m_valid && !bus.m_ready) stall_m++;
    if (phase == 1 && outstanding == 0 && pops < len && !bus.fifo_read_ready) starve_m++;
`endif
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    @(posedge clk);
    cyc++;
    if (pop) begin
      outstanding++;
      pops++;
    end
    if (hs) begin
      outstanding--;
      beats++;
      last_hs = cyc;
      if (beats == 1) first_hs = cyc;
    end
    if (phase == 2) phase = 0;
    else if (phase == 1 && hs && beats == len) begin
      phase = 2;
      check("pops_per_burst", 64'(pops), 64'(len));
    end else if (acc) begin
      phase = 1;
      len = int'(bus.burst_len);
      beats = 0;
      pops = 0;
      acc_cyc = cyc;
    end
    #1;
    if (pop) bus.fifo_read_data = fifo_q.pop_front();
    bus.burst_start = 1'b0;
    bus.m_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) :
                  rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    refresh();
  endtask

  task automatic start(input int l);
    bus.burst_start = 1'b1;
    bus.burst_len = LW'(l);
    cycle();
  endtask

  task automatic run(input int maxc);
    for (int n = 0; n < maxc && phase != 0; n++) cycle();
    check("burst_completes", 64'(phase), 64'(0));
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_req", 64'(bus.fifo_read_req), 64'(0));
    check("arst_valid", 64'(bus.m_valid), 64'(0));
    check("arst_last", 64'(bus.m_last), 64'(0));
    check("arst_data", 64'(bus.m_data), 64'(0));
    check("arst_ready", 64'(bus.burst_ready), 64'(1));
    check("arst_done", 64'(bus.burst_done), 64'(0));
    fifo_q.delete();
    exp_q.delete();
    phase = 0;
    outstanding = 0;
    prev_stall = 1'b0;
`ifdef FIFO_RD_STREAMER_PERF_EN
    stall_m = 0;
    starve_m = 0;
`endif
    bus.fifo_read_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef FIFO_RD_STREAMER_PERF_EN
    logic [31:0] s0;
`endif
    bus.burst_start = 1'b0;
    bus.burst_len = '0;
    bus.fifo_read_ready = 1'b0;
    bus.fifo_read_data = '0;
    bus.m_ready = 1'b1;
    #12;
    check("rst_ready", 64'(bus.burst_ready), 64'(1));
    check("rst_valid", 64'(bus.m_valid), 64'(0));
    check("rst_req", 64'(bus.fifo_read_req), 64'(0));
    check("rst_data", 64'(bus.m_data), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    // four beats, FIFO full, sink always ready
    push(4, 64'hA0, 1'b0);
    start(4);
    run(40);
    check("first_beat_latency", 64'(first_hs - acc_cyc), 64'(3));
    check("back_to_back", 64'(last_hs - first_hs), 64'(3));
    // 1,0,0,1 backpressure
    rdy_mode = 1;
    push(6, '0, 1'b1);
    start(6);
    run(100);
    // FIFO runs dry after two beats
    rdy_mode = 0;
    push(2, '0, 1'b1);
    start(5);
    repeat (9) cycle();
    check("gap_valid_low", 64'(bus.m_valid), 64'(0));
    check("gap_beats", 64'(beats), 64'(2));
    push(3, '0, 1'b1);
    run(40);
    // zero-length command, then a command during an active burst
    start(0);
    repeat (3) cycle();
    push(3, '0, 1'b1);
    start(3);
    cycle();
    bus.burst_start = 1'b1;
    bus.burst_len = LW'(5);
    cycle();
    run(40);
    repeat (4) cycle();
    check("exp_drained", 64'(exp_q.size()), 64'(0));
    // async reset during beat 2 of 8, then a clean 2-beat burst
    push(8, '0, 1'b1);
    start(8);
    for (int n = 0; n < 50 && beats < 2; n++) cycle();
    do_reset_mid();
    push(2, 64'h55, 1'b0);
    start(2);
    run(40);
    // sink holds off for ten cycles once data is presented
    rdy_mode = 3;
    push(4, '0, 1'b1);
    start(4);
    for (int n = 0; n < 20 && !bus.m_valid; n++) cycle();
`ifdef FIFO_RD_STREAMER_PERF_EN
    s0 = stall_cycles;
`endif
    repeat (10) cycle();
`ifdef FIFO_RD_STREAMER_PERF_EN
    check("stall_10", 64'(stall_cycles - s0), 64'(10));
`endif
    rdy_mode = 0;
    bus.m_ready = 1'b1;
    run(40);
    // random lengths, random backpressure, random FIFO gaps
    rdy_mode = 2;
    fifo_rand = 1'b1;
    for (int b = 0; b < 12; b++) begin
      int l;
      l = $urandom_range(1, 20);
      push(l, '0, 1'b1);
      start(l);
      run(500);
    end
    fifo_rand = 1'b0;
    rdy_mode = 0;
    repeat (3) cycle();
    check("final_drained", 64'(exp_q.size()), 64'(0));
`ifdef FIFO_RD_STREAMER_PERF_EN
    check("stall_cycles", 64'(stall_cycles), 64'(stall_m));
    check("starve_cycles", 64'(starve_cycles), 64'(starve_m));
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
